// File: rtl/circular_step_generator_pkg.sv
// -----------------------------------------------------------------------------
// Processor_PKG
// Shared types for the circular-arc step generator.
//   BYTE_BITS        : default coordinate width
//   CircStepState_t  : FSM state encoding of circular_step_generator
//   step_move_t      : one unit axis move (enable + direction per axis,
//                      direction 1 = +1, 0 = -1)
// -----------------------------------------------------------------------------
package Processor_PKG;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } CircStepState_t;

  typedef struct packed {
    logic x_en;
    logic x_dir;
    logic y_en;
    logic y_dir;
  } step_move_t;

endpackage

// File: rtl/circular_step_generator_chooser.sv
// -----------------------------------------------------------------------------
// circular_step_chooser
// Purely combinational move selection for one step along a circular arc.
// Picks the tangent direction from the quadrant of the current point and,
// when both axes may move, the axis whose resulting error term is smaller.
//   i_is_cw      : 1 = clockwise, 0 = counter-clockwise
//   i_cur_x/y    : current point relative to the arc centre (signed)
//   i_err        : x^2 + y^2 - r^2 at the current point
//   o_move       : chosen axis move (exactly one enable set)
//   o_next_err   : error term after the chosen move
// -----------------------------------------------------------------------------
module circular_step_chooser
  import Processor_PKG::*;
#(
  parameter int NUM_BITS = BYTE_BITS
) (
  input  logic                         i_is_cw,
  input  logic signed [NUM_BITS-1:0]   i_cur_x,
  input  logic signed [NUM_BITS-1:0]   i_cur_y,
  input  logic signed [2*NUM_BITS+1:0] i_err,
  output step_move_t                   o_move,
  output logic signed [2*NUM_BITS+1:0] o_next_err
);

  localparam int ERR_BITS = 2 * NUM_BITS + 2;
  localparam logic signed [ERR_BITS-1:0] ONE = ERR_BITS'(1);

  logic signed [ERR_BITS-1:0] w_two_x;
  logic signed [ERR_BITS-1:0] w_two_y;
  logic signed [ERR_BITS-1:0] w_ex;
  logic signed [ERR_BITS-1:0] w_ey;
  logic signed [ERR_BITS-1:0] w_abs_ex;
  logic signed [ERR_BITS-1:0] w_abs_ey;
  logic                       w_sx_nz;
  logic                       w_sx_pos;
  logic                       w_sy_nz;
  logic                       w_sy_pos;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    o_move     = '0;
    o_next_err = '0;

    // Sign-extend before doubling so the error arithmetic never wraps.
    w_two_x = ERR_BITS'(i_cur_x) + ERR_BITS'(i_cur_x);
    w_two_y = ERR_BITS'(i_cur_y) + ERR_BITS'(i_cur_y);

    // Quadrant-derived tangent: x follows -sign(y) for CCW, +sign(y) for CW;
    // y follows +sign(x) for CCW, -sign(x) for CW. "_nz" false means sign 0.
    w_sx_nz  = (i_cur_y != '0);
    w_sx_pos = i_is_cw ? ~i_cur_y[NUM_BITS-1] : i_cur_y[NUM_BITS-1];
    w_sy_nz  = (i_cur_x != '0);
    w_sy_pos = i_is_cw ? i_cur_x[NUM_BITS-1] : ~i_cur_x[NUM_BITS-1];

    // (c +/- 1)^2 - c^2 = +/-2c + 1
    w_ex = w_sx_pos ? (i_err + w_two_x + ONE) : (i_err - w_two_x + ONE);
    w_ey = w_sy_pos ? (i_err + w_two_y + ONE) : (i_err - w_two_y + ONE);

    w_abs_ex = w_ex[ERR_BITS-1] ? -w_ex : w_ex;
    w_abs_ey = w_ey[ERR_BITS-1] ? -w_ey : w_ey;

    if (!w_sx_nz) begin
      o_move.y_en  = 1'b1;
      o_move.y_dir = w_sy_pos;
      o_next_err   = w_ey;
    end else if (!w_sy_nz || (w_abs_ex <= w_abs_ey)) begin
      o_move.x_en  = 1'b1;
      o_move.x_dir = w_sx_pos;
      o_next_err   = w_ex;
    end else begin
      o_move.y_en  = 1'b1;
      o_move.y_dir = w_sy_pos;
      o_next_err   = w_ey;
    end
  end

endmodule

// File: rtl/circular_step_generator.sv
// -----------------------------------------------------------------------------
// circular_step_generator
// Emits a sequence of unit X/Y steps that trace a circular arc around the
// origin, one step per accepted valid/ready handshake.
//   clk, reset              : clock, asynchronous active-low reset
//   start / ready           : arc request, accepted only while ready (IDLE)
//   is_cw, start_x, start_y,
//   r, num_steps            : arc parameters, sampled on accept
//   step_valid / step_ready : step handshake towards the motor stage
//   step_{x,y}_{en,dir}     : presented move, dir 1 = +1, 0 = -1
//   cur_x, cur_y            : current position relative to the centre
//   done                    : one-cycle pulse when the arc completes
// -----------------------------------------------------------------------------
module circular_step_generator
  import Processor_PKG::*;
#(
  parameter int NUM_BITS = BYTE_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  input  logic                  is_cw,
  input  logic [NUM_BITS-1:0]   start_x,
  input  logic [NUM_BITS-1:0]   start_y,
  input  logic [NUM_BITS-1:0]   r,
  input  logic [NUM_BITS+2:0]   num_steps,
  output logic                  step_valid,
  input  logic                  step_ready,
  output logic                  step_x_en,
  output logic                  step_x_dir,
  output logic                  step_y_en,
  output logic                  step_y_dir,
  output logic [NUM_BITS-1:0]   cur_x,
  output logic [NUM_BITS-1:0]   cur_y,
  output logic                  done
);

  localparam int STEP_BITS = NUM_BITS + 3;
  localparam int ERR_BITS  = 2 * NUM_BITS + 2;

  CircStepState_t              r_state;
  CircStepState_t              w_next_state;
  logic                        r_is_cw;
  logic [NUM_BITS-1:0]         r_r;
  logic [STEP_BITS-1:0]        r_num_steps;
  logic [STEP_BITS-1:0]        r_remaining;
  logic signed [NUM_BITS-1:0]  r_cur_x;
  logic signed [NUM_BITS-1:0]  r_cur_y;
  logic signed [ERR_BITS-1:0]  r_err;

  step_move_t                  w_move;
  logic signed [ERR_BITS-1:0]  w_next_err;
  logic signed [ERR_BITS-1:0]  w_cx;
  logic signed [ERR_BITS-1:0]  w_cy;
  logic signed [ERR_BITS-1:0]  w_rr;
  logic signed [ERR_BITS-1:0]  w_load_err;
  logic [NUM_BITS-1:0]         w_x_delta;
  logic [NUM_BITS-1:0]         w_y_delta;
  logic                        w_fire;

  circular_step_chooser #(
    .NUM_BITS (NUM_BITS)
  ) u_chooser (
    .i_is_cw    (r_is_cw),
    .i_cur_x    (r_cur_x),
    .i_cur_y    (r_cur_y),
    .i_err      (r_err),
    .o_move     (w_move),
    .o_next_err (w_next_err)
  );

  // Initial error of the start point; coordinates sign-extend, radius is
  // unsigned and zero-extends.
  assign w_cx       = ERR_BITS'(r_cur_x);
  assign w_cy       = ERR_BITS'(r_cur_y);
  assign w_rr       = ERR_BITS'(r_r);
  assign w_load_err = w_cx * w_cx + w_cy * w_cy - w_rr * w_rr;

  // +1 when dir=1, all-ones (-1) when dir=0.
  assign w_x_delta = {{(NUM_BITS-1){~w_move.x_dir}}, 1'b1};
  assign w_y_delta = {{(NUM_BITS-1){~w_move.y_dir}}, 1'b1};

  assign cur_x = r_cur_x;
  assign cur_y = r_cur_y;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    step_valid   = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_next_state = (r_num_steps == '0) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        step_valid = 1'b1;
        if (step_ready && (r_remaining == STEP_BITS'(1))) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase

    // Step outputs depend only on registered state, so they hold steady
    // for as long as the motor stage stalls.
    step_x_en  = step_valid & w_move.x_en;
    step_x_dir = step_valid & w_move.x_dir;
    step_y_en  = step_valid & w_move.y_en;
    step_y_dir = step_valid & w_move.y_dir;
    w_fire     = step_valid & step_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_cw     <= 1'b0;
      r_r         <= '0;
      r_num_steps <= '0;
      r_remaining <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_err       <= '0;
    end else begin
      if (ready && start) begin
        r_is_cw     <= is_cw;
        r_r         <= r;
        r_num_steps <= num_steps;
        r_cur_x     <= start_x;
        r_cur_y     <= start_y;
      end
      if (r_state == ST_LOAD) begin
        r_err       <= w_load_err;
        r_remaining <= r_num_steps;
      end
      if (w_fire) begin
        if (w_move.x_en) r_cur_x <= r_cur_x + w_x_delta;
        if (w_move.y_en) r_cur_y <= r_cur_y + w_y_delta;
        r_err       <= w_next_err;
        r_remaining <= r_remaining - STEP_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_circular_step_generator.sv
// -----------------------------------------------------------------------------
// tb_circular_step_generator
// Directed arcs with hand-derived move sequences. Issuing an arc pushes the
// expected moves (with the pre-step position and error) into a queue; a
// monitor pops and compares on every accepted step.
// Move letters: X = x+1, x = x-1, Y = y+1, y = y-1.
// -----------------------------------------------------------------------------
module tb_circular_step_generator;

  localparam int NB = 8;
  localparam int SB = NB + 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 ready;
  logic                 is_cw = 1'b0;
  logic [NB-1:0]        start_x = '0;
  logic [NB-1:0]        start_y = '0;
  logic [NB-1:0]        r = '0;
  logic [SB-1:0]        num_steps = '0;
  logic                 step_valid;
  logic                 step_ready = 1'b1;
  logic                 step_x_en, step_x_dir, step_y_en, step_y_dir;
  logic signed [NB-1:0] cur_x, cur_y;
  logic                 done;

  circular_step_generator #(.NUM_BITS(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ready      (ready),
    .is_cw      (is_cw),
    .start_x    (start_x),
    .start_y    (start_y),
    .r          (r),
    .num_steps  (num_steps),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_x_en  (step_x_en),
    .step_x_dir (step_x_dir),
    .step_y_en  (step_y_en),
    .step_y_dir (step_y_dir),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mv;   // {x_en, x_dir, y_en, y_dir}
    int         x;
    int         y;
    int         err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_fired  = 0;
  int   done_cnt = 0;
  int   acc_cyc  = 0;
  int   fin_x    = 0;
  int   fin_y    = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (step_valid && step_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step: step presented with no expected step at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        check("step_move", {step_x_en, step_x_dir, step_y_en, step_y_dir}, mon_e.mv);
        check("step_cur_x", cur_x, mon_e.x);
        check("step_cur_y", cur_y, mon_e.y);
        check("step_err", dut.r_err, mon_e.err);
        n_fired++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue_arc(input logic cw, input int sx, input int sy,
                           input int rr, input string mv);
    int   px, py, budget;
    exp_t e;
    px = sx;
    py = sy;
    for (int i = 0; i < mv.len(); i++) begin
      e.x   = px;
      e.y   = py;
      e.err = px * px + py * py - rr * rr;
      case (mv[i])
        "X":     begin e.mv = 4'b1100; px++; end
        "x":     begin e.mv = 4'b1000; px--; end
        "Y":     begin e.mv = 4'b0011; py++; end
        default: begin e.mv = 4'b0010; py--; end
      endcase
      q.push_back(e);
    end
    fin_x   = px;
    fin_y   = py;
    n_fired = 0;
    budget  = 0;
    while (!ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("ready_before_start", ready, 1);
    is_cw     = cw;
    start_x   = NB'(sx);
    start_y   = NB'(sy);
    r         = NB'(rr);
    num_steps = SB'(mv.len());
    start     = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    acc_cyc = cyc;
    @(negedge clk);
    check("load_no_step", step_valid, 0);
    check("load_not_ready", ready, 0);
    check("load_cur_x", cur_x, sx);
    check("load_cur_y", cur_y, sy);
    if (mv.len() > 0) begin
      @(negedge clk);
      check("first_step_latency", step_valid, 1);
    end
  endtask

  task automatic wait_done(input int exp_lat);
    int budget;
    bit seen;
    budget = 0;
    seen   = 1'b0;
    while (budget < 200) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      budget++;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_latency", cyc - acc_cyc, exp_lat);
      check("final_x", cur_x, fin_x);
      check("final_y", cur_y, fin_y);
      check("done_not_ready", ready, 0);
      check("done_no_step", step_valid, 0);
      check("queue_drained", q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("ready_back", ready, 1);
      check("hold_x", cur_x, fin_x);
      check("hold_y", cur_y, fin_y);
    end
  endtask

  task automatic wait_fired(input int n);
    int budget;
    budget = 0;
    while (n_fired < n && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    check("wait_fired", n_fired, n);
  endtask

  logic [15:0] snap;
  int          d0;

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", step_valid, 0);
    check("rst_step_bits", {step_x_en, step_x_dir, step_y_en, step_y_dir}, 0);
    check("rst_done", done, 0);
    check("rst_cur", {cur_x, cur_y}, 0);
    check("rst_err", dut.r_err, 0);
    check("rst_remaining", dut.r_remaining, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Quarter arc CCW (4,0)->(0,4); a start mid-arc must be ignored.
    issue_arc(1'b0, 4, 0, 4, "YYxYxYxx");
    @(posedge clk); #1;
    is_cw = 1'b1; start_x = 8'hF9; r = 8'd2; num_steps = 11'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(9);

    // Full circle CCW, 32 steps back to (4,0).
    issue_arc(1'b0, 4, 0, 4, {"YYxYxYxx", "xxyxyxyy", "yyXyXyXX", "XXYXYXYY"});
    wait_done(33);

    // Quarter arc CW (0,4)->(4,0).
    issue_arc(1'b1, 0, 4, 4, "XXyXyXyy");
    wait_done(9);

    // Zero steps: straight LOAD -> DONE.
    issue_arc(1'b0, 4, 0, 4, "");
    wait_done(1);

    // Back-pressure: stall three cycles after the third step.
    issue_arc(1'b0, 4, 0, 4, "YYxYxYxx");
    wait_fired(3);
    step_ready = 1'b0;
    snap = {step_valid, step_x_en, step_x_dir, step_y_en, step_y_dir, 3'b000, cur_x};
    check("stall_pos_x", cur_x, 3);
    check("stall_pos_y", cur_y, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_outputs",
            {step_valid, step_x_en, step_x_dir, step_y_en, step_y_dir, 3'b000, cur_x}, snap);
      check("stall_cur_y", cur_y, 2);
      @(posedge clk);
    end
    #1 step_ready = 1'b1;
    wait_done(12);

    // Reset while the third step is presented.
    issue_arc(1'b0, 4, 0, 4, "YYxYxYxx");
    wait_fired(2);
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_valid", step_valid, 0);
    check("midrst_step_bits", {step_x_en, step_x_dir, step_y_en, step_y_dir}, 0);
    check("midrst_cur", {cur_x, cur_y}, 0);
    check("midrst_err", dut.r_err, 0);
    check("midrst_remaining", dut.r_remaining, 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_cnt, d0);
    check("midrst_idle", ready, 1);
    @(posedge clk); #1;

    // A new arc after the mid-arc reset.
    issue_arc(1'b1, 0, 4, 4, "XXyXyXyy");
    wait_done(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
